// File: rtl/rbsp_pkg.sv
// Shared constants for the RBSP bit buffer and the syntax parsers that read it.
package rbsp_pkg;
   localparam int BUF_BITS = 64;
   localparam int WIN_BITS = 32;
   localparam int FILL_W   = 7;
   localparam int FWD_W    = 6;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_FWD,
      CMD_ALIGN,
      CMD_FLUSH
   } cmd_e;
endpackage

// File: rtl/rbsp_bit_packer.sv
// Combinational shift/insert: drops i_shift consumed bits from the MSB end of the
// buffer and, when i_wr is set, appends i_byte right after the remaining bits.
module rbsp_bit_packer
   import rbsp_pkg::*;
#(
   parameter int BUF_BITS = rbsp_pkg::BUF_BITS
) (
   input  logic [BUF_BITS-1:0] i_buf,
   input  logic [FILL_W-1:0]   i_fill,
   input  logic [FWD_W-1:0]    i_shift,
   input  logic [7:0]          i_byte,
   input  logic                i_wr,
   output logic [BUF_BITS-1:0] o_buf,
   output logic [FILL_W-1:0]   o_fill
);

   logic [FILL_W-1:0]   w_fill_rem;
   logic [BUF_BITS-1:0] w_ins;

   // The write condition keeps w_fill_rem <= BUF_BITS-8, so the byte never truncates.
   assign w_fill_rem = i_fill - FILL_W'(i_shift);
   assign w_ins      = {i_byte, {(BUF_BITS-8){1'b0}}} >> w_fill_rem;
   assign o_buf      = (i_buf << i_shift) | (i_wr ? w_ins : '0);
   assign o_fill     = w_fill_rem + (i_wr ? FILL_W'(8) : '0);

endmodule

// File: rtl/rbsp_buffer.sv
// MSB-aligned RBSP bit buffer: pulls bytes from the NAL reader and serves a
// peek window plus forward/align/flush commands to the syntax parsers.
module rbsp_buffer
   import rbsp_pkg::*;
#(
   parameter int BUF_BITS = rbsp_pkg::BUF_BITS,
   parameter int WIN_BITS = rbsp_pkg::WIN_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [7:0]          rbsp_data_in,
   input  logic                rbsp_valid_in,
   output logic                rd_req_out,
   input  logic                forward_valid_in,
   input  logic [FWD_W-1:0]    forward_len_in,
   input  logic                align_in,
   input  logic                flush_in,
   output logic [WIN_BITS-1:0] window_out,
   output logic [FILL_W-1:0]   fill_bits_out,
   output logic [31:0]         bit_offset_out,
   output logic                underflow_err_out
);

   logic [BUF_BITS-1:0] r_buf;
   logic [FILL_W-1:0]   r_fill;
   logic [31:0]         r_bit_off;
   logic                r_err;

   cmd_e                w_cmd;
   logic [FWD_W-1:0]    w_shift;
   logic                w_err_set;
   logic                w_wr;
   logic [BUF_BITS-1:0] w_buf_next;
   logic [FILL_W-1:0]   w_fill_next;

   always_comb begin
      w_cmd = CMD_NONE;
      if (flush_in)              w_cmd = CMD_FLUSH;
      else if (align_in)         w_cmd = CMD_ALIGN;
      else if (forward_valid_in) w_cmd = CMD_FWD;
   end

   // Over-length forwards (including the illegal >WIN_BITS range) consume nothing.
   always_comb begin
      w_shift   = '0;
      w_err_set = 1'b0;
      case (w_cmd)
         CMD_ALIGN: w_shift = FWD_W'(r_fill[2:0]);
         CMD_FWD: begin
            if (forward_len_in <= FWD_W'(WIN_BITS) && FILL_W'(forward_len_in) <= r_fill)
               w_shift = forward_len_in;
            else
               w_err_set = 1'b1;
         end
         default: ;
      endcase
   end

   assign rd_req_out = ena & ~rst & ~flush_in & (r_fill <= FILL_W'(BUF_BITS-8));
   assign w_wr       = rd_req_out & rbsp_valid_in;

   rbsp_bit_packer #(.BUF_BITS(BUF_BITS)) u_packer (
      .i_buf   (r_buf),
      .i_fill  (r_fill),
      .i_shift (w_shift),
      .i_byte  (rbsp_data_in),
      .i_wr    (w_wr),
      .o_buf   (w_buf_next),
      .o_fill  (w_fill_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf     <= '0;
         r_fill    <= '0;
         r_bit_off <= '0;
         r_err     <= 1'b0;
      end else if (ena) begin
         if (w_cmd == CMD_FLUSH) begin
            r_buf     <= '0;
            r_fill    <= '0;
            r_bit_off <= '0;
            r_err     <= 1'b0;
         end else begin
            r_buf     <= w_buf_next;
            r_fill    <= w_fill_next;
            r_bit_off <= r_bit_off + 32'(w_shift);
            r_err     <= r_err | w_err_set;
         end
      end
   end

   assign window_out        = r_buf[BUF_BITS-1 -: WIN_BITS];
   assign fill_bits_out     = r_fill;
   assign bit_offset_out    = r_bit_off;
   assign underflow_err_out = r_err;

endmodule

// File: tb/tb_rbsp_buffer.sv
// Bench for rbsp_buffer: a bit-queue reference model feeds a scoreboard checked
// every cycle, plus directed scenario checks against hand-derived constants.
module tb_rbsp_buffer;

   logic        clk = 1'b0;
   logic        rst, ena, rbsp_valid_in, forward_valid_in, align_in, flush_in;
   logic [7:0]  rbsp_data_in;
   logic [5:0]  forward_len_in;
   logic        rd_req_out;
   logic [31:0] window_out;
   logic [6:0]  fill_bits_out;
   logic [31:0] bit_offset_out;
   logic        underflow_err_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rbsp_buffer dut (
      .clk               (clk),
      .rst               (rst),
      .ena               (ena),
      .rbsp_data_in      (rbsp_data_in),
      .rbsp_valid_in     (rbsp_valid_in),
      .rd_req_out        (rd_req_out),
      .forward_valid_in  (forward_valid_in),
      .forward_len_in    (forward_len_in),
      .align_in          (align_in),
      .flush_in          (flush_in),
      .window_out        (window_out),
      .fill_bits_out     (fill_bits_out),
      .bit_offset_out    (bit_offset_out),
      .underflow_err_out (underflow_err_out)
   );

   typedef struct {
      bit          chk;
      logic [31:0] win;
      logic [6:0]  fill;
      logic [31:0] off;
      logic        err;
      logic        rq;
   } exp_t;

   exp_t        sbq[$];
   bit          mq[$];
   logic [31:0] m_off;
   bit          m_err;
   bit          m_known = 0;

   function automatic logic [31:0] m_window();
      logic [31:0] w = '0;
      for (int i = 0; i < 32; i++)
         if (i < mq.size()) w[31-i] = mq[i];
      return w;
   endfunction

   // Apply one cycle of stimulus, record the expected current-state outputs,
   // advance the model, then return just after the clock edge.
   task automatic step(input bit r, input bit e, input bit v, input logic [7:0] d,
                       input bit f, input logic [5:0] l, input bit a, input bit fl,
                       output logic rq);
      exp_t x;
      bit   m_rq;
      int   n;
      rst = r; ena = e; rbsp_valid_in = v; rbsp_data_in = d;
      forward_valid_in = f; forward_len_in = l; align_in = a; flush_in = fl;
      m_rq = e && !r && !fl && (mq.size() <= 56);
      x.chk = m_known; x.win = m_window(); x.fill = 7'(mq.size());
      x.off = m_off; x.err = m_err; x.rq = m_rq;
      sbq.push_back(x);
      #1 rq = rd_req_out;
      if (r) begin
         mq.delete(); m_off = 0; m_err = 0; m_known = 1;
      end else if (e) begin
         if (fl) begin
            mq.delete(); m_off = 0; m_err = 0;
         end else begin
            n = 0;
            if (a) n = mq.size() % 8;
            else if (f) begin
               if (int'(l) <= 32 && int'(l) <= mq.size()) n = int'(l);
               else m_err = 1;
            end
            repeat (n) void'(mq.pop_front());
            m_off = m_off + 32'(n);
            if (m_rq && v)
               for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (sbq.size() > 0) begin
         x = sbq.pop_front();
         if (x.chk) begin
            total++;
            if (window_out !== x.win || fill_bits_out !== x.fill || bit_offset_out !== x.off ||
                underflow_err_out !== x.err || rd_req_out !== x.rq) begin
               bad++;
               $display("FAIL sb t=%0t got win=%h fill=%0d off=%0d err=%b rq=%b exp win=%h fill=%0d off=%0d err=%b rq=%b",
                        $time, window_out, fill_bits_out, bit_offset_out, underflow_err_out, rd_req_out,
                        x.win, x.fill, x.off, x.err, x.rq);
            end
         end
      end
   end

   logic rq;

   task automatic feed(input logic [7:0] d, input bit v);
      step(0, 1, v, d, 0, 0, 0, 0, rq);
   endtask

   task automatic fwd(input logic [5:0] l);
      step(0, 1, 0, 8'h00, 1, l, 0, 0, rq);
   endtask

   task automatic flush();
      step(0, 1, 0, 8'h00, 0, 0, 0, 1, rq);
   endtask

   task automatic test_reset();
      step(1, 1, 1, 8'hEE, 1, 6'd4, 0, 0, rq);
      total++; if (rq !== 1'b0) begin bad++; $display("FAIL rst_rdreq got=%b exp=0", rq); end
      step(1, 0, 0, 8'h00, 0, 0, 0, 0, rq);
      total++;
      if (window_out !== 32'h0 || fill_bits_out !== 7'd0 || bit_offset_out !== 32'd0 || underflow_err_out !== 1'b0) begin
         bad++; $display("FAIL rst_state got win=%h fill=%0d off=%0d err=%b exp 0", window_out, fill_bits_out, bit_offset_out, underflow_err_out);
      end
   endtask

   task automatic test_fill();
      feed(8'hA5, 1);
      total++; if (rq !== 1'b1) begin bad++; $display("FAIL rdreq_after_rst got=%b exp=1", rq); end
      feed(8'h3C, 1); feed(8'hFF, 1); feed(8'h00, 1);
      total++;
      if (fill_bits_out !== 7'd32 || window_out !== 32'hA53CFF00 || bit_offset_out !== 32'd0) begin
         bad++; $display("FAIL fill4 got fill=%0d win=%h off=%0d exp 32 a53cff00 0", fill_bits_out, window_out, bit_offset_out);
      end
      feed(8'h55, 1); feed(8'h66, 1); feed(8'h77, 1);
      feed(8'h88, 1);
      total++; if (rq !== 1'b1) begin bad++; $display("FAIL rdreq_fill56 got=%b exp=1", rq); end
      feed(8'h99, 1);
      total++; if (rq !== 1'b0) begin bad++; $display("FAIL rdreq_full got=%b exp=0", rq); end
      total++;
      if (fill_bits_out !== 7'd64 || window_out !== 32'hA53CFF00) begin
         bad++; $display("FAIL full_hold got fill=%0d win=%h exp 64 a53cff00", fill_bits_out, window_out);
      end
      fwd(6'd33);
      total++;
      if (underflow_err_out !== 1'b1 || fill_bits_out !== 7'd64) begin
         bad++; $display("FAIL fwd33 got err=%b fill=%0d exp 1 64", underflow_err_out, fill_bits_out);
      end
   endtask

   task automatic test_fwd_write();
      flush();
      feed(8'hA5, 1); feed(8'h3C, 1); feed(8'hFF, 1); feed(8'h00, 1);
      step(0, 1, 1, 8'h81, 1, 6'd3, 0, 0, rq);
      total++;
      if (fill_bits_out !== 7'd37 || window_out !== 32'h29E7F804 || bit_offset_out !== 32'd3) begin
         bad++; $display("FAIL fwd_write got fill=%0d win=%h off=%0d exp 37 29e7f804 3", fill_bits_out, window_out, bit_offset_out);
      end
   endtask

   task automatic test_align();
      step(0, 1, 0, 8'h00, 0, 0, 1, 0, rq);
      total++;
      if (fill_bits_out !== 7'd32 || window_out !== 32'h3CFF0081 || bit_offset_out !== 32'd8) begin
         bad++; $display("FAIL align got fill=%0d win=%h off=%0d exp 32 3cff0081 8", fill_bits_out, window_out, bit_offset_out);
      end
      step(0, 1, 0, 8'h00, 1, 6'd5, 1, 0, rq);
      total++;
      if (fill_bits_out !== 7'd32 || bit_offset_out !== 32'd8) begin
         bad++; $display("FAIL align_noop got fill=%0d off=%0d exp 32 8", fill_bits_out, bit_offset_out);
      end
      fwd(6'd1);
      step(0, 1, 1, 8'h5A, 0, 0, 1, 0, rq);
      total++;
      if (fill_bits_out !== 7'd32 || window_out !== 32'hFF00815A || bit_offset_out !== 32'd16) begin
         bad++; $display("FAIL align_write got fill=%0d win=%h off=%0d exp 32 ff00815a 16", fill_bits_out, window_out, bit_offset_out);
      end
   endtask

   task automatic test_ena();
      step(0, 0, 1, 8'h77, 1, 6'd8, 0, 0, rq);
      total++; if (rq !== 1'b0) begin bad++; $display("FAIL ena_rdreq got=%b exp=0", rq); end
      step(0, 0, 0, 8'h00, 0, 0, 0, 1, rq);
      total++;
      if (fill_bits_out !== 7'd32 || window_out !== 32'hFF00815A || bit_offset_out !== 32'd16) begin
         bad++; $display("FAIL ena_hold got fill=%0d win=%h off=%0d exp 32 ff00815a 16", fill_bits_out, window_out, bit_offset_out);
      end
   endtask

   task automatic test_underflow();
      flush();
      feed(8'hB8, 1);
      fwd(6'd3);
      fwd(6'd7);
      total++;
      if (fill_bits_out !== 7'd5 || underflow_err_out !== 1'b1 || window_out !== 32'hC0000000 || bit_offset_out !== 32'd3) begin
         bad++; $display("FAIL underflow got fill=%0d err=%b win=%h off=%0d exp 5 1 c0000000 3", fill_bits_out, underflow_err_out, window_out, bit_offset_out);
      end
      step(0, 1, 1, 8'hAA, 0, 0, 0, 1, rq);
      total++; if (rq !== 1'b0) begin bad++; $display("FAIL flush_rdreq got=%b exp=0", rq); end
      total++;
      if (fill_bits_out !== 7'd0 || underflow_err_out !== 1'b0 || bit_offset_out !== 32'd0 || window_out !== 32'h0) begin
         bad++; $display("FAIL flush got fill=%0d err=%b off=%0d win=%h exp 0 0 0 0", fill_bits_out, underflow_err_out, bit_offset_out, window_out);
      end
      fwd(6'd1);
      total++; if (underflow_err_out !== 1'b1) begin bad++; $display("FAIL empty_fwd got err=%b exp=1", underflow_err_out); end
   endtask

   task automatic test_alternate();
      flush();
      feed(8'h11, 1); feed(8'h22, 0); feed(8'h33, 1); feed(8'h44, 0);
      total++;
      if (window_out !== 32'h11330000 || fill_bits_out !== 7'd16) begin
         bad++; $display("FAIL alternate got win=%h fill=%0d exp 11330000 16", window_out, fill_bits_out);
      end
      step(0, 1, 0, 8'h00, 1, 6'd8, 1, 1, rq);
      total++;
      if (fill_bits_out !== 7'd0 || underflow_err_out !== 1'b0 || bit_offset_out !== 32'd0) begin
         bad++; $display("FAIL flush_wins got fill=%0d err=%b off=%0d exp 0 0 0", fill_bits_out, underflow_err_out, bit_offset_out);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
              8'($urandom), $urandom_range(0, 2) == 0, 6'($urandom_range(0, 40)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, rq);
   endtask

   initial begin
      rst = 1; ena = 0; rbsp_valid_in = 0; rbsp_data_in = 0;
      forward_valid_in = 0; forward_len_in = 0; align_in = 0; flush_in = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_fwd_write();
      test_align();
      test_ena();
      test_underflow();
      test_alternate();
      test_back_to_back();
      step(0, 1, 0, 8'h00, 0, 0, 0, 0, rq);
      total++;
      if (sbq.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d exp=0", sbq.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rbsp_buffer.md
Name: rbsp_buffer

Overview:
- Bit-level RBSP buffer directly downstream of the NAL reader.
- Pulls emulation-prevention-stripped RBSP bytes from the NAL reader one per request cycle and packs them into a 64-bit MSB-aligned bit buffer.
- Presents a 32-bit peek window to the syntax parsers (exp-Golomb, fixed-length fields) and consumes 1..32 bits per cycle on their command.
- Also provides byte alignment and a flush at NAL boundaries.

Parameters:
- BUF_BITS, 64, total buffer capacity in bits; must be a multiple of 8 and at least WIN_BITS+8.
- WIN_BITS, 32, peek window width and maximum forward length.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ena  in  1  global enable; when low, all state holds and rd_req_out is 0
- rbsp_data_in  in  8  current RBSP byte from the NAL reader
- rbsp_valid_in  in  1  rbsp_data_in is a payload byte (low for skipped 0x03 bytes and header/ref_idc=0 bytes)
- rd_req_out  out  1  request/advance to the NAL reader; the byte is taken this cycle if rbsp_valid_in=1
- forward_valid_in  in  1  consume forward_len_in bits this cycle
- forward_len_in  in  6  bits to consume, 0..32
- align_in  in  1  discard bits up to the next byte boundary
- flush_in  in  1  empty the buffer (new NAL)
- window_out  out  32  next 32 unconsumed bits; window_out[31] is the oldest; bits beyond fill are 0
- fill_bits_out  out  7  unconsumed bit count, 0..64
- bit_offset_out  out  32  bits consumed since the last flush or reset
- underflow_err_out  out  1  sticky; set by an over-length forward; cleared by rst or flush

Behaviour:
- Reset (clk edge with rst=1): buffer=0, fill=0, bit_offset=0, underflow_err=0.
  - window_out=0, fill_bits_out=0.
  - rd_req_out=0 while rst=1.
- rd_req_out = ena & !rst & !flush_in & (fill_bits <= BUF_BITS-8). This is combinational from registered fill, and is 1 immediately after reset release.
- Byte write occurs when rd_req_out & rbsp_valid_in, in the same cycle.
  - The byte is appended after the bits that remain following this cycle's consumption.
  - The NAL reader advances on every rd_req_out regardless of valid; invalid cycles are dropped and fill is unchanged by them.
- Command priority per cycle: rst > flush_in > align_in > forward_valid_in. A lower-priority command asserted together with a higher one is ignored, with no error.
- flush_in:
  - Next state: buffer=0, fill=0, bit_offset=0, underflow_err=0.
  - No byte is written in this cycle (rd_req_out is forced to 0).
- align_in:
  - Discards d = fill mod 8 bits: buffer <<= d, fill -= d, bit_offset += d.
  - With d=0 it is a no-op.
  - A byte write in the same cycle is allowed.
- forward_valid_in with len L:
  - If L <= fill: buffer <<= L, fill -= L, bit_offset += L.
  - If L > fill: no consumption and underflow_err set. Parsers must wait until fill_bits_out >= needed.
  - L=0 is a no-op. L>32 is illegal; treat it as the L>fill case.
- Simultaneous consume of L and write:
  - fill_next = fill - L + 8.
  - buffer_next = (buffer << L) | (byte << (BUF_BITS-8-(fill-L))).
  - The write condition guarantees fill-L <= 56, so no truncation.
- Latency: a byte written at edge N is visible in window_out/fill_bits_out after edge N; a consume at edge N shifts the window after edge N. No combinational path from forward_*/align_in to window_out.
- Full: fill in 57..64 means rd_req_out=0 and the NAL reader stalls.
- Empty: window_out=0, fill=0; a forward of L>=1 raises the error.
- bit_offset_out wraps modulo 2^32.
- ena=0: all registers hold; commands are ignored.

Decomposition:
- Shared package rbsp_pkg holds constants BUF_BITS=64, WIN_BITS=32, FILL_W=7, FWD_W=6, used also by the parser stages.
- One natural sub-module: rbsp_bit_packer, a combinational shift/insert computing buffer_next from buffer, fill, shift amount, byte and write-enable.
- FSM-free top: registers plus command priority logic.

Test Plan:
- Reset release, feed bytes 0xA5,0x3C,0xFF,0x00 all valid → after 4 cycles fill_bits_out=32, window_out=0xA53CFF00, bit_offset_out=0.
- Keep feeding valid bytes with no consumption → rd_req_out drops when fill=64; the 9th byte is not requested and the NAL reader is stalled.
- Fill=32 (window 0xA53CFF00), forward 3 plus write of 0x81 in the same cycle → fill=37, window_out=0x29E7F804, bit_offset=3.
- After consuming 3 bits, assert align_in → 5 bits discarded, fill=multiple of 8, bit_offset=8, window begins 0x3C.
- Fill=5, forward 7 → no shift, fill stays 5, underflow_err_out=1. Then flush_in → fill=0, error cleared, bit_offset=0, rd_req_out=0 during the flush cycle.
- rbsp_valid_in alternating 1/0 with data 0x11,0x22,0x33,0x44 (the 0x22 and 0x44 cycles invalid) → window_out=0x11330000, fill=16; flush_in and forward_valid_in together → flush wins.
